alu_exe_pipe: RTL and testbench

//   Parametrised integer ALU execute pipe between the issue/regfile-read stage and commit.

---
 rtl/alu_exe_pkg.sv | 41 ++++
 rtl/alu_exe_pipe_core.sv | 43 ++++
 rtl/alu_exe_pipe.sv | 138 +++++++++++++
 tb/tb_alu_exe_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exe_pkg.sv
// Shared types for the integer ALU execute pipe.
//   alu_op_e   : 4-bit ALU opcode set understood by alu_core.
//   exe_uop_t  : issued uop as seen by the execute stage (default widths).
//   res_uop_t  : computed result travelling towards commit (default widths).
// The DEF_* widths match the default parameters of alu_exe_pipe; pipes built
// with other widths declare equivalent local types from their parameters.
package alu_exe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PREG_W = 6;
  localparam int DEF_ROB_W  = 6;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SLT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOR = 4'd6,
    OP_SLL = 4'd7,
    OP_SR  = 4'd8,
    OP_LUI = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] src0;
    logic [DEF_DATA_W-1:0] src1;
    logic                  signed_op;
    logic [3:0]            op;
    logic [DEF_PREG_W-1:0] pdest;
    logic [DEF_ROB_W-1:0]  rob;
  } exe_uop_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_PREG_W-1:0] pdest;
    logic [DEF_ROB_W-1:0]  rob;
  } res_uop_t;

endpackage

// File: rtl/alu_exe_pipe_core.sv
// Purely combinational integer ALU.
//   src0, src1 : operands (src1 already muxed with the immediate)
//   signed_op  : selects signed compare / arithmetic right shift
//   op         : alu_op_e opcode; undefined codes produce 0
//   res        : result, add/sub wrap modulo 2^DATA_W
module alu_core
  import alu_exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  input  logic              signed_op,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] res
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  logic            lt;

  assign shamt = src1[SH_W-1:0];
  assign lt    = signed_op ? ($signed(src0) < $signed(src1)) : (src0 < src1);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = src0 + src1;
      OP_SUB:  res = src0 - src1;
      OP_SLT:  res = {{(DATA_W-1){1'b0}}, lt};
      OP_AND:  res = src0 & src1;
      OP_OR:   res = src0 | src1;
      OP_XOR:  res = src0 ^ src1;
      OP_NOR:  res = ~(src0 | src1);
      OP_SLL:  res = src0 << shamt;
      OP_SR:   res = signed_op ? DATA_W'($signed(src0) >>> shamt) : (src0 >> shamt);
      OP_LUI:  res = src1;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_exe_pipe.sv
// Integer ALU execute pipe: issue handshake in, STAGES register stages,
// commit handshake out. s1 holds operands, s2..sSTAGES hold the result.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush_i         : kill every in-flight uop and the same-cycle capture
//   exe_*           : issue port (valid/ready) with operands, op, pdest, rob
//   cmt_*           : commit port (valid/ready) with result, pdest, rob, we
//
// Handshake: a transfer happens at a rising edge where valid and ready are
// both 1. Ready never depends on valid of the same port, valid/payload of a
// producer stay stable until the transfer completes. The ready chain is
// combinational from cmt_ready_i: a stage is ready when it is empty or when
// every stage below it up to commit can drain this cycle.
module alu_exe_pipe
  import alu_exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              exe_valid_i,
  output logic              exe_ready_o,
  input  logic [DATA_W-1:0] exe_src0_i,
  input  logic [DATA_W-1:0] exe_src1_i,
  input  logic [DATA_W-1:0] exe_imm_i,
  input  logic              exe_imm_vld_i,
  input  logic              exe_signed_i,
  input  logic [3:0]        exe_op_i,
  input  logic [PREG_W-1:0] exe_pdest_i,
  input  logic [ROB_W-1:0]  exe_rob_i,
  output logic              cmt_valid_o,
  input  logic              cmt_ready_i,
  output logic              cmt_we_o,
  output logic [DATA_W-1:0] cmt_wdata_o,
  output logic [PREG_W-1:0] cmt_pdest_o,
  output logic [ROB_W-1:0]  cmt_rob_o
);

  if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
    $error("alu_exe_pipe: STAGES must be in 2..6");
  end

  typedef struct packed {
    logic [DATA_W-1:0] src0;
    logic [DATA_W-1:0] src1;
    logic              signed_op;
    logic [3:0]        op;
    logic [PREG_W-1:0] pdest;
    logic [ROB_W-1:0]  rob;
  } s1_uop_t;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [PREG_W-1:0] pdest;
    logic [ROB_W-1:0]  rob;
  } res_t;

  logic [STAGES:1]   vld;
  logic [STAGES+1:1] rdy;
  s1_uop_t           s1_q;
  res_t              res_q [2:STAGES];
  logic [DATA_W-1:0] alu_res;

  // Each rdy bit is derived directly from vld so the chain has no
  // self-referencing vector: stage i may advance if commit takes an entry
  // or any stage from i down to the last one holds a bubble.
  always_comb begin
    rdy = '0;
    rdy[STAGES+1] = cmt_ready_i;
    for (int i = 1; i <= STAGES; i++) begin
      rdy[i] = cmt_ready_i;
      for (int j = i; j <= STAGES; j++) begin
        if (!vld[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign exe_ready_o = rdy[1];

  // s1: operand capture, immediate mux applied before the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld[1] <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (flush_i)     vld[1] <= 1'b0;
      else if (rdy[1]) vld[1] <= exe_valid_i;
      if (!flush_i && rdy[1] && exe_valid_i) begin
        s1_q.src0      <= exe_src0_i;
        s1_q.src1      <= exe_imm_vld_i ? exe_imm_i : exe_src1_i;
        s1_q.signed_op <= exe_signed_i;
        s1_q.op        <= exe_op_i;
        s1_q.pdest     <= exe_pdest_i;
        s1_q.rob       <= exe_rob_i;
      end
    end
  end

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .src0      (s1_q.src0),
    .src1      (s1_q.src1),
    .signed_op (s1_q.signed_op),
    .op        (s1_q.op),
    .res       (alu_res)
  );

  // s2 captures the ALU result, later stages copy it unchanged.
  for (genvar i = 2; i <= STAGES; i++) begin : g_stg
    res_t res_in;
    if (i == 2) begin : g_first
      assign res_in = {alu_res, s1_q.pdest, s1_q.rob};
    end else begin : g_copy
      assign res_in = res_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld[i]   <= 1'b0;
        res_q[i] <= '0;
      end else begin
        if (flush_i)     vld[i] <= 1'b0;
        else if (rdy[i]) vld[i] <= vld[i-1];
        if (rdy[i] && vld[i-1]) res_q[i] <= res_in;
      end
    end
  end

  assign cmt_valid_o = vld[STAGES];
  assign cmt_wdata_o = res_q[STAGES].wdata;
  assign cmt_pdest_o = res_q[STAGES].pdest;
  assign cmt_rob_o   = res_q[STAGES].rob;
  // preg 0 is hardwired zero, so it is never written.
  assign cmt_we_o    = cmt_valid_o && (res_q[STAGES].pdest != '0);

endmodule

// File: tb/tb_alu_exe_pipe.sv
// Directed bench for alu_exe_pipe. Two instances share every input:
// dut_a uses STAGES=2, dut_b uses STAGES=4 (back-pressure test).
module tb_alu_exe_pipe;
  import alu_exe_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          exe_valid;
  logic [DW-1:0] exe_src0, exe_src1, exe_imm;
  logic          exe_imm_vld, exe_signed;
  logic [3:0]    exe_op;
  logic [5:0]    exe_pdest, exe_rob;
  logic          cmt_ready;

  logic          a_ready, a_valid, a_we;
  logic [DW-1:0] a_wdata;
  logic [5:0]    a_pdest, a_rob;
  logic          b_ready, b_valid, b_we;
  logic [DW-1:0] b_wdata;
  logic [5:0]    b_pdest, b_rob;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exe_pipe #(.DATA_W(DW), .PREG_W(6), .ROB_W(6), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .exe_valid_i(exe_valid), .exe_ready_o(a_ready),
    .exe_src0_i(exe_src0), .exe_src1_i(exe_src1), .exe_imm_i(exe_imm),
    .exe_imm_vld_i(exe_imm_vld), .exe_signed_i(exe_signed), .exe_op_i(exe_op),
    .exe_pdest_i(exe_pdest), .exe_rob_i(exe_rob),
    .cmt_valid_o(a_valid), .cmt_ready_i(cmt_ready), .cmt_we_o(a_we),
    .cmt_wdata_o(a_wdata), .cmt_pdest_o(a_pdest), .cmt_rob_o(a_rob)
  );

  alu_exe_pipe #(.DATA_W(DW), .PREG_W(6), .ROB_W(6), .STAGES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .exe_valid_i(exe_valid), .exe_ready_o(b_ready),
    .exe_src0_i(exe_src0), .exe_src1_i(exe_src1), .exe_imm_i(exe_imm),
    .exe_imm_vld_i(exe_imm_vld), .exe_signed_i(exe_signed), .exe_op_i(exe_op),
    .exe_pdest_i(exe_pdest), .exe_rob_i(exe_rob),
    .cmt_valid_o(b_valid), .cmt_ready_i(cmt_ready), .cmt_we_o(b_we),
    .cmt_wdata_o(b_wdata), .cmt_pdest_o(b_pdest), .cmt_rob_o(b_rob)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                       input logic [DW-1:0] imm, input logic iv, input logic sg,
                       input logic [5:0] pd, input logic [5:0] rb);
    exe_valid = 1'b1; exe_op = op; exe_src0 = s0; exe_src1 = s1; exe_imm = imm;
    exe_imm_vld = iv; exe_signed = sg; exe_pdest = pd; exe_rob = rb;
  endtask

  task automatic idle();
    exe_valid = 1'b0;
  endtask

  initial begin
    int accepted;
    int got;
    int seen;
    logic [DW-1:0] e;

    rst_n = 1'b0; flush = 1'b0; cmt_ready = 1'b1;
    exe_valid = 1'b0; exe_src0 = '0; exe_src1 = '0; exe_imm = '0;
    exe_imm_vld = 1'b0; exe_signed = 1'b0; exe_op = 4'd0; exe_pdest = '0; exe_rob = '0;
    #2;
    check("rst_valid", a_valid, 1'b0);
    check("rst_wdata", a_wdata, 32'h0);
    check("rst_we", a_we, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    check("rst_ready", a_ready, 1'b1);

    // 1: back-to-back ADD, SUB, SLT signed
    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 6'd1, 6'd1);
    tick();
    check("t1_lat_valid", a_valid, 1'b0);
    issue(OP_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 6'd2, 6'd2);
    tick();
    check("t1_add_valid", a_valid, 1'b1);
    check("t1_add", a_wdata, 32'd12);
    check("t1_add_rob", a_rob, 6'd1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 6'd3, 6'd3);
    tick();
    check("t1_sub", a_wdata, 32'hFFFF_FFFE);
    idle();
    tick();
    check("t1_slt", a_wdata, 32'd1);
    check("t1_slt_pdest", a_pdest, 6'd3);
    tick();
    check("t1_drain", a_valid, 1'b0);

    // 2: immediate and shifts
    issue(OP_ADD, 32'd1, 32'hDEAD, 32'h10, 1'b1, 1'b0, 6'd4, 6'd4);
    tick();
    issue(OP_SR, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b1, 6'd5, 6'd5);
    tick();
    check("t2_imm", a_wdata, 32'h11);
    issue(OP_SR, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 6'd6, 6'd6);
    tick();
    check("t2_sra", a_wdata, 32'hF800_0000);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 6'd7, 6'd7);
    tick();
    check("t2_srl", a_wdata, 32'h0800_0000);
    idle();
    tick();
    check("t2_sltu", a_wdata, 32'd0);
    repeat (4) tick();

    // 3: back-pressure on the 4-stage instance
    cmt_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      issue(OP_ADD, 32'(100 + k), 32'(k), 32'd0, 1'b0, 1'b0, 6'(k + 1), 6'(k + 10));
      if (b_ready) begin
        accepted++;
        exp_q.push_back(32'(100 + 2 * k));
      end
      tick();
    end
    check("t3_accepted", accepted, 4);
    check("t3_ready_low", b_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t3_stable_valid", b_valid, 1'b1);
      check("t3_stable_wdata", b_wdata, 32'd100);
      check("t3_stable_rob", b_rob, 6'd10);
      tick();
    end
    idle();
    cmt_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (b_valid) begin
        if (exp_q.size() == 0) begin
          check("t3_extra_commit", b_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("t3_order", b_wdata, e);
          got++;
        end
      end
      tick();
    end
    check("t3_count", got, 4);
    check("t3_left", exp_q.size(), 0);

    // 4: flush with a full pipe plus a same-cycle issue
    cmt_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 6'd5, 6'd20);
    tick();
    issue(OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 6'd5, 6'd21);
    tick();
    check("t4_full", a_ready, 1'b0);
    cmt_ready = 1'b1;
    flush = 1'b1;
    issue(OP_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 6'd5, 6'd22);
    #1;
    check("t4_ready_when_draining", a_ready, 1'b1);
    tick();
    flush = 1'b0;
    idle();
    check("t4_flush_valid", a_valid, 1'b0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (a_valid || b_valid) seen++;
      tick();
    end
    check("t4_no_stale", seen, 0);
    issue(OP_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 1'b0, 6'd7, 6'd23);
    tick();
    idle();
    tick();
    check("t4_after_valid", a_valid, 1'b1);
    check("t4_after_wdata", a_wdata, 32'd42);
    repeat (4) tick();

    // 5: pdest 0 and undefined opcode
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 6'd0, 6'd30);
    tick();
    issue(4'hF, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, 6'd3, 6'd31);
    tick();
    check("t5_p0_valid", a_valid, 1'b1);
    check("t5_p0_we", a_we, 1'b0);
    check("t5_p0_wdata", a_wdata, 32'd2);
    idle();
    tick();
    check("t5_undef_valid", a_valid, 1'b1);
    check("t5_undef_we", a_we, 1'b1);
    check("t5_undef_wdata", a_wdata, 32'd0);
    repeat (4) tick();

    // 6: asynchronous reset mid-stream
    issue(OP_OR, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0, 6'd9, 6'd40);
    tick();
    tick();
    check("t6_pre_valid", a_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", a_valid, 1'b0);
    check("t6_we", a_we, 1'b0);
    check("t6_wdata", a_wdata, 32'd0);
    check("t6_pdest", a_pdest, 6'd0);
    check("t6_rob", a_rob, 6'd0);
    idle();
    #2 rst_n = 1'b1;
    tick();
    check("t6_ready", a_ready, 1'b1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (a_valid || b_valid) seen++;
      tick();
    end
    check("t6_no_stale", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
